// File: rtl/paddle_scan_ctrl.sv
// Per-frame paddle timer sequencer: trigger, time both pulses, publish positions.
// Optional 2-tap position smoothing when PADDLE_SCAN_FILTER_EN is defined.
module paddle_scan_ctrl #(
   parameter int TRG_CYCLES = 143,
   parameter int PRESCALE   = 64
) (
   input  logic       CLK_DRV,
   input  logic       RESET,
   input  logic       FRAME_START,
   input  logic       PAD1_OUT,
   input  logic       PAD2_OUT,
   output logic       PAD_TRG_N,
   output logic [7:0] PAD1_POS,
   output logic [7:0] PAD2_POS,
   output logic       PAD1_TMO,
   output logic       PAD2_TMO,
   output logic       POS_VALID
);

   typedef enum logic [1:0] {
      IDLE,
      TRIG,
      MEASURE,
      DONE
   } state_t;

   localparam logic [15:0] TMAX = 16'(TRG_CYCLES);
   localparam logic [9:0]  PMAX = 10'(PRESCALE - 1);

   state_t      state, state_nx;
   logic [15:0] trg_cnt;
   logic [9:0]  presc;
   logic [7:0]  step;
   logic [7:0]  cnt [2];
   logic [7:0]  pub [2];
   logic [1:0]  done, tmo, pad;
   logic        tick, trg_end, tmo_hit;

   assign pad     = {PAD2_OUT, PAD1_OUT};
   assign tick    = (presc == PMAX);
   assign trg_end = (trg_cnt == TMAX);
   assign tmo_hit = tick && (step == 8'd254);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (FRAME_START) state_nx = TRIG;
         TRIG:    if (trg_end) state_nx = MEASURE;
         MEASURE: if ((&done) || tmo_hit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Trigger register trails the TRIG state by one edge.
   always_ff @(posedge CLK_DRV or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         trg_cnt   <= '0;
         PAD_TRG_N <= 1'b1;
      end else begin
         state     <= state_nx;
         PAD_TRG_N <= !((state == TRIG) && !trg_end);
         if ((state == TRIG) && !trg_end)
            trg_cnt <= trg_cnt + 16'd1;
         else
            trg_cnt <= '0;
      end
   end

   always_ff @(posedge CLK_DRV or posedge RESET) begin
      if (RESET) begin
         presc <= '0;
         step  <= '0;
         done  <= '0;
         tmo   <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else if (state == TRIG) begin
         presc <= '0;
         step  <= '0;
         done  <= '0;
         tmo   <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else if (state == MEASURE) begin
         presc <= tick ? 10'd0 : presc + 10'd1;
         if (tick) step <= step + 8'd1;
         for (int i = 0; i < 2; i++) begin
            if (!done[i]) begin
               if (!pad[i]) begin
                  done[i] <= 1'b1;
               end else if (tmo_hit) begin
                  cnt[i] <= 8'd255;
                  tmo[i] <= 1'b1;
               end else if (tick && (cnt[i] != 8'd255)) begin
                  cnt[i] <= cnt[i] + 8'd1;
               end
            end
         end
      end
   end

`ifdef PADDLE_SCAN_FILTER_EN
   logic [7:0] prev_raw [2];
   logic       prev_ok;

   function automatic logic [7:0] avg2(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + 9'd1;
      return s[8:1];
   endfunction

   // The first scan after reset has no history, so it goes out raw.
   always_comb begin
      for (int i = 0; i < 2; i++)
         pub[i] = prev_ok ? avg2(prev_raw[i], cnt[i]) : cnt[i];
   end

   always_ff @(posedge CLK_DRV or posedge RESET) begin
      if (RESET) begin
         prev_ok <= 1'b0;
         for (int i = 0; i < 2; i++) prev_raw[i] <= '0;
      end else if (state == DONE) begin
         prev_ok <= 1'b1;
         for (int i = 0; i < 2; i++) prev_raw[i] <= cnt[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 2; i++) pub[i] = cnt[i];
   end
`endif

   always_ff @(posedge CLK_DRV or posedge RESET) begin
      if (RESET) begin
         PAD1_POS  <= '0;
         PAD2_POS  <= '0;
         PAD1_TMO  <= 1'b0;
         PAD2_TMO  <= 1'b0;
         POS_VALID <= 1'b0;
      end else begin
         POS_VALID <= (state == DONE);
         if (state == DONE) begin
            PAD1_POS <= pub[0];
            PAD2_POS <= pub[1];
            PAD1_TMO <= tmo[0];
            PAD2_TMO <= tmo[1];
         end
      end
   end

endmodule

// File: tb/tb_paddle_scan_ctrl.sv
// Bench for paddle_scan_ctrl: directed table, random scans, reset corner cases.
// Expected positions come from floor(N/PRESCALE) with a 255 limit.
module tb_paddle_scan_ctrl;

   localparam int TRG = 143;
   localparam int PS  = 64;
   localparam int LIM = 255 * PS;

   logic       CLK_DRV = 1'b0;
   logic       RESET;
   logic       FRAME_START;
   logic       PAD1_OUT;
   logic       PAD2_OUT;
   logic       PAD_TRG_N;
   logic [7:0] PAD1_POS;
   logic [7:0] PAD2_POS;
   logic       PAD1_TMO;
   logic       PAD2_TMO;
   logic       POS_VALID;

   int applied     = 0;
   int miscompares = 0;
   int prev_m [2];
   bit have_m;

   paddle_scan_ctrl #(
      .TRG_CYCLES(TRG),
      .PRESCALE  (PS)
   ) dut (
      .CLK_DRV    (CLK_DRV),
      .RESET      (RESET),
      .FRAME_START(FRAME_START),
      .PAD1_OUT   (PAD1_OUT),
      .PAD2_OUT   (PAD2_OUT),
      .PAD_TRG_N  (PAD_TRG_N),
      .PAD1_POS   (PAD1_POS),
      .PAD2_POS   (PAD2_POS),
      .PAD1_TMO   (PAD1_TMO),
      .PAD2_TMO   (PAD2_TMO),
      .POS_VALID  (POS_VALID)
   );

   always #5 CLK_DRV = ~CLK_DRV;

   typedef struct {
      int n1;
      int n2;
      int pos1;
      bit tmo1;
      int pos2;
      bit tmo2;
      bit fs_trig;
      bit fs_meas;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      applied++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int raw_pos(input int n);
      return (n / PS > 255) ? 255 : n / PS;
   endfunction

   function automatic int raw_tmo(input int n);
      return (n >= LIM) ? 1 : 0;
   endfunction

   task automatic model_publish(input int r1, input int r2,
                                output int p1, output int p2);
`ifdef PADDLE_SCAN_FILTER_EN
      if (have_m) begin
         p1 = (prev_m[0] + r1 + 1) / 2;
         p2 = (prev_m[1] + r2 + 1) / 2;
      end else begin
         p1 = r1;
         p2 = r2;
      end
`else
      p1 = r1;
      p2 = r2;
`endif
      prev_m[0] = r1;
      prev_m[1] = r2;
      have_m = 1'b1;
   endtask

   task automatic trig_phase(input bit fs_trig, input string tag);
      int c;
      int low;
      @(posedge CLK_DRV); #1 FRAME_START = 1'b1;
      @(posedge CLK_DRV); #1 FRAME_START = 1'b0;
      @(negedge CLK_DRV);
      chk({tag, " trg_at_k"}, PAD_TRG_N, 1);
      c = 0;
      while (PAD_TRG_N && c < 4) begin
         @(negedge CLK_DRV);
         c++;
      end
      chk({tag, " trg_latency"}, c, 1);
      low = 0;
      while (!PAD_TRG_N && low < TRG + 10) begin
         low++;
         FRAME_START = fs_trig && (low == 20);
         @(negedge CLK_DRV);
      end
      FRAME_START = 1'b0;
      chk({tag, " trg_width"}, low, TRG);
   endtask

   task automatic run_scan(input vec_t v, input string tag);
      int c, got, gc, p1, p2, extra;
      logic [7:0] cp1, cp2;
      logic ct1, ct2;
      cp1 = '0; cp2 = '0; ct1 = 0; ct2 = 0;
      trig_phase(v.fs_trig, tag);
      got = 0; gc = 0; c = 0;
      while (c < LIM + 20) begin
         c++;
         PAD1_OUT    = (c <= v.n1);
         PAD2_OUT    = (c <= v.n2);
         FRAME_START = v.fs_meas && (c == 100);
         @(negedge CLK_DRV);
         if (POS_VALID) begin
            if (got == 0) begin
               cp1 = PAD1_POS; cp2 = PAD2_POS;
               ct1 = PAD1_TMO; ct2 = PAD2_TMO;
            end
            got++;
            gc = c;
         end
         if (got > 0 && c >= gc + 4) break;
      end
      FRAME_START = 1'b0;
      PAD1_OUT = 1'b0;
      PAD2_OUT = 1'b0;
      chk({tag, " valid_count"}, got, 1);
      model_publish(v.pos1, v.pos2, p1, p2);
      chk({tag, " pos1"}, cp1, p1);
      chk({tag, " tmo1"}, ct1, v.tmo1);
      chk({tag, " pos2"}, cp2, p2);
      chk({tag, " tmo2"}, ct2, v.tmo2);
      chk({tag, " hold_pos1"}, PAD1_POS, p1);
      chk({tag, " hold_pos2"}, PAD2_POS, p2);
      extra = 0;
      repeat (20) begin
         @(negedge CLK_DRV);
         if (!PAD_TRG_N || POS_VALID) extra++;
      end
      chk({tag, " no_retrigger"}, extra, 0);
   endtask

   initial begin
      vec_t v;
      int   cnt;
      RESET       = 1'b1;
      FRAME_START = 1'b0;
      PAD1_OUT    = 1'b0;
      PAD2_OUT    = 1'b0;
      have_m      = 1'b0;

      vecs[0] = '{640,     6400,  10,  0, 100, 0, 0, 0};
      vecs[1] = '{1000000, 64,    255, 1, 1,   0, 0, 0};
      vecs[2] = '{700,     0,     10,  0, 0,   0, 1, 1};
      vecs[3] = '{63,      65,    0,   0, 1,   0, 0, 0};
      vecs[4] = '{6400,    3264,  100, 0, 51,  0, 0, 0};
      vecs[5] = '{3264,    6400,  51,  0, 100, 0, 0, 0};
      vecs[6] = '{LIM - 1, LIM,   254, 0, 255, 1, 0, 0};

      #12;
      chk("rst trg_n", PAD_TRG_N, 1);
      chk("rst pos1", PAD1_POS, 0);
      chk("rst pos2", PAD2_POS, 0);
      chk("rst tmo", {PAD1_TMO, PAD2_TMO}, 0);
      chk("rst valid", POS_VALID, 0);
      @(negedge CLK_DRV);
      RESET = 1'b0;

      for (int i = 0; i < 7; i++)
         run_scan(vecs[i], $sformatf("vec%0d", i));

      trig_phase(1'b0, "rst_meas");
      PAD1_OUT = 1'b1;
      PAD2_OUT = 1'b1;
      repeat (500) @(negedge CLK_DRV);
      RESET = 1'b1;
      #1;
      chk("rst_meas trg_n", PAD_TRG_N, 1);
      chk("rst_meas pos1", PAD1_POS, 0);
      chk("rst_meas pos2", PAD2_POS, 0);
      chk("rst_meas tmo", {PAD1_TMO, PAD2_TMO}, 0);
      chk("rst_meas valid", POS_VALID, 0);
      have_m = 1'b0;
      repeat (3) @(negedge CLK_DRV);
      RESET = 1'b0;
      cnt = 0;
      repeat (300) begin
         @(negedge CLK_DRV);
         if (POS_VALID || !PAD_TRG_N) cnt++;
      end
      chk("rst_meas quiet", cnt, 0);
      PAD1_OUT = 1'b0;
      PAD2_OUT = 1'b0;

      @(posedge CLK_DRV); #1 FRAME_START = 1'b1;
      @(posedge CLK_DRV); #1 FRAME_START = 1'b0;
      repeat (10) @(negedge CLK_DRV);
      chk("rst_trig low", PAD_TRG_N, 0);
      RESET = 1'b1;
      #1;
      chk("rst_trig trg_n", PAD_TRG_N, 1);
      repeat (2) @(negedge CLK_DRV);
      RESET = 1'b0;

      for (int i = 0; i < 6; i++) begin
         v.n1 = (i == 0) ? 0 : int'($urandom_range(0, 2500));
         v.n2 = int'($urandom_range(0, 2500));
         v.pos1 = raw_pos(v.n1);
         v.tmo1 = raw_tmo(v.n1) != 0;
         v.pos2 = raw_pos(v.n2);
         v.tmo2 = raw_tmo(v.n2) != 0;
         v.fs_trig = 1'b0;
         v.fs_meas = 1'b0;
         run_scan(v, $sformatf("rnd%0d n1=%0d n2=%0d", i, v.n1, v.n2));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscompares);
      $finish;
   end

endmodule

// File: doc/paddle_scan_ctrl.md
# paddle_scan_ctrl

Frame-synchronous sequencer for the two 555-style analog paddle timers. Once per video frame it fires the shared active-low trigger (PAD_TRG_N), times the high pulse returned on PAD1_OUT and PAD2_OUT, and publishes two 8-bit paddle positions with timeout flags. It sits between the board-level input synchronizers and pongtop's paddle logic, in the CLK_DRV (14.318 MHz) domain.

## Interface
- TRG_CYCLES, 143: width of the trigger low pulse in CLK_DRV cycles (about 10 µs). Legal range 1..65535.
- PRESCALE, 64: CLK_DRV cycles per position step. Legal range 2..1024.
- CLK_DRV  in  1  drive clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FRAME_START  in  1  single-cycle pulse marking the start of vertical sync.
- PAD1_OUT  in  1  paddle 1 timer output, already synchronized.
- PAD2_OUT  in  1  paddle 2 timer output, already synchronized.
- PAD_TRG_N  out  1  registered, active-low trigger shared by both timers.
- PAD1_POS  out  8  paddle 1 position; 0 means shortest pulse.
- PAD2_POS  out  8  paddle 2 position.
- PAD1_TMO  out  1  paddle 1 hit the 255-step limit in the last scan.
- PAD2_TMO  out  1  paddle 2 hit the 255-step limit in the last scan.
- POS_VALID  out  1  one-cycle strobe: positions and flags were updated.

## Operation
- The FSM has four states: IDLE, TRIG, MEASURE, DONE.
- IDLE:
  - PAD_TRG_N is 1.
  - When FRAME_START is sampled 1, go to TRIG.
- TRIG:
  - PAD_TRG_N is 0.
  - A 16-bit counter runs for exactly TRG_CYCLES cycles, then the FSM goes to MEASURE.
- MEASURE:
  - On entry, clear the prescaler, the step counter, the per-pad counters cnt1 and cnt2 (8-bit each), and the done bits done1 and done2.
  - Prescaler counts 0..PRESCALE-1 and wraps. A tick is the cycle where the prescaler equals PRESCALE-1.
  - Step counter (8-bit) increments on each tick.
  - For each pad x: while done_x=0 and PADx_OUT=1, cnt_x increments on each tick, saturating at 255.
  - The first cycle PADx_OUT is sampled 0 sets done_x=1.
  - A pad is measured at most once per scan. Later rising edges are ignored.
  - Timeout: when a tick brings the step counter to 255, every pad with done_x=0 gets cnt_x=255 and tmo_x=1.
  - Leave to DONE when both done bits are 1, or on timeout.
- DONE (one cycle):
  - Load PADx_POS from cnt_x and PADx_TMO from tmo_x.
  - Pulse POS_VALID.
  - Return to IDLE.
- FRAME_START outside IDLE is ignored; it is neither queued nor allowed to restart a scan.
- Arithmetic: for a pad high for N cycles counted from MEASURE entry, POS = min(floor(N/PRESCALE), 255).
- PADx_OUT already 0 on the first MEASURE cycle gives POS=0 and TMO=0.

## Timing
- Reset values:
  - PAD_TRG_N=1
  - PAD1_POS=PAD2_POS=0
  - PAD1_TMO=PAD2_TMO=0
  - POS_VALID=0
  - FSM in IDLE, all counters 0
- FRAME_START high at edge k: PAD_TRG_N falls at edge k+1 and rises at edge k+1+TRG_CYCLES. The first MEASURE cycle follows edge k+1+TRG_CYCLES.
- POS_VALID goes high on the same edge the outputs change and lasts exactly one cycle.
- PADx_POS and PADx_TMO hold their value between strobes.
- Worst-case scan length is TRG_CYCLES + 255·PRESCALE + 2 cycles (16 465 with defaults), well inside one frame.
- RESET mid-scan: immediately force PAD_TRG_N=1, clear all outputs, and return to IDLE. No partial result is published.

## Configuration
- PADDLE_SCAN_FILTER_EN defined:
  - A per-pad last-raw register is loaded in DONE.
  - Published POS = (prev_raw + new_raw + 1) >> 1, computed in 9 bits.
  - TMO is not filtered.
  - prev_raw resets to 0, and the first scan after reset publishes the raw value.
- Not defined: POS is the raw count, with no extra registers.

## Test plan
- Reset, then FRAME_START pulse: PAD_TRG_N low for exactly 143 cycles starting the cycle after the pulse.
- PAD1 high 640 cycles and PAD2 high 6400 cycles after MEASURE entry: POS_VALID once; PAD1_POS=10, PAD2_POS=100, both TMO=0.
- PAD1 stuck high, PAD2 drops after 64 cycles: POS_VALID at 255 steps; PAD1_POS=255, PAD1_TMO=1, PAD2_POS=1, PAD2_TMO=0.
- PAD2 0 at MEASURE entry: PAD2_POS=0. Extra FRAME_START pulses during TRIG and MEASURE cause no second trigger.
- RESET asserted mid-MEASURE: PAD_TRG_N=1, POS=0, no POS_VALID. The next FRAME_START starts a clean scan.
- With PADDLE_SCAN_FILTER_EN, raw 100 then raw 51: published 100, then 76.
